io_wr_arbiter: RTL and testbench
================================

Name: io_wr_arbiter

Overview:
Shares a bank of NUM_PORTS 8-bit IO output registers between two write requesters: the CPU store path (req0) and the debug/loader path (req1). Arbitrates round-robin and decodes the target port. Sequences the registered-write-enable timing of the IO registers: the enable is captured on one edge and the data is committed on the next. Returns a one-cycle ack to the winning requester once the data is visible on the register output.

Parameters:
NUM_PORTS, 4, number of IO registers driven (1..2**ADDR_W)
ADDR_W, 2, width of requester port address

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req0  in  1  CPU write request, held until ack0
addr0  in  ADDR_W  CPU target port index
data0  in  8  CPU write data
ack0  out  1  one-cycle completion pulse for requester 0
req1  in  1  debug write request, held until ack1
addr1  in  ADDR_W  debug target port index
data1  in  8  debug write data
ack1  out  1  one-cycle completion pulse for requester 1
err  out  1  valid only while ack0/ack1 is high; 1 = transaction failed
busy  out  1  high whenever state != IDLE
io_wr_en  out  NUM_PORTS  one-hot write enable, bit i to IO register i
io_wdata  out  8  shared write data to all IO registers
io_rdata  in  NUM_PORTS*8  IO register outputs, port i at bits [8i+7:8i]

Behaviour:
- Reset (async, rst high): state=IDLE; ack0, ack1, err, busy = 0; io_wr_en = 0; io_wdata = 0; last_grant = 1 (requester 0 wins the first tie). Any in-flight transaction is dropped with no ack.
- FSM states: IDLE, ISSUE, HOLD, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant it.
  - Both req: grant the requester not equal to last_grant.
  - On grant: latch winner id, addr and data into internal registers.
  - If latched addr >= NUM_PORTS: go to DONE with err_pending=1.
  - Otherwise: go to ISSUE.
- ISSUE (1 cycle): io_wr_en[addr]=1, all other bits 0; io_wdata = latched data. Next state HOLD.
- HOLD (1 cycle): io_wr_en = 0; io_wdata held at latched data. The IO register commits on the edge ending this cycle. Next state DONE.
- DONE (1 cycle): ack of the granted requester = 1; err = err_pending; last_grant = winner. Next state IDLE.
- io_wdata holds its last value in IDLE and DONE. It changes only when a new transaction is latched.
- Latency for a valid address: req seen in IDLE at edge N; ISSUE in cycle N+1; HOLD in N+2; ack in N+3. io_rdata reflects the new data during the ack cycle. Minimum spacing is 4 cycles per transaction.
- Requests and operands are sampled only in IDLE. Changes on req/addr/data after the grant do not affect the transaction.
- A requester that drops req before its ack is still completed and acked.
- A requester holding req through IDLE after its ack starts a new transaction. Fairness: when both requesters hold req continuously, grants alternate 0,1,0,1,...
- Never more than one io_wr_en bit high. io_wr_en is never high for more than one consecutive cycle.
- Out-of-range address: io_wr_en stays 0; ack arrives 1 cycle after grant with err=1.
- busy is high in ISSUE, HOLD and DONE.

Optional Feature:
Macro IO_READBACK_EN.
- Defined: in DONE, for valid addresses, err = (io_rdata[port addr] != latched data). A readback mismatch is reported on the ack.
- Undefined: io_rdata is ignored (port still present). err is set only for out-of-range addresses.

Test Plan:
1. Reset, then req0=1, addr0=2, data0=8'hA5 -> io_wr_en=4'b0100 for exactly one cycle; ack0 at grant+3 with err=0; io_rdata port 2 = A5 in the ack cycle.
2. req0 and req1 asserted in the same cycle (addr0=0/data0=11, addr1=1/data1=22), both held -> req0 acked first, then req1. Ports 0=11 and 1=22; acks 4 cycles apart.
3. Both reqs held continuously for 6 transactions -> grant order 0,1,0,1,0,1; busy drops for exactly 1 IDLE cycle between transactions.
4. NUM_PORTS=3, req1 with addr1=3 -> io_wr_en stays 0; ack1 one cycle after grant with err=1; all registers unchanged.
5. Assert rst during HOLD -> all outputs 0 immediately; no ack; state IDLE; a following req completes normally.
6. With IO_READBACK_EN, drive io_rdata port 1 to 8'h00 while writing 8'h3C -> ack with err=1. Without the macro, the same stimulus gives err=0.

Source files
------------

// File: rtl/io_wr_arbiter.sv
// Round-robin arbiter that shares a bank of 8-bit IO output registers between two write requesters.
// Optional IO_READBACK_EN: reports a readback mismatch on the ack.
module io_wr_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ADDR_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0,
  input  logic [ADDR_W-1:0]      addr0,
  input  logic [7:0]             data0,
  output logic                   ack0,
  input  logic                   req1,
  input  logic [ADDR_W-1:0]      addr1,
  input  logic [7:0]             data1,
  output logic                   ack1,
  output logic                   err,
  output logic                   busy,
  output logic [NUM_PORTS-1:0]   io_wr_en,
  output logic [7:0]             io_wdata,
  input  logic [NUM_PORTS*8-1:0] io_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StHold, StDone} state_e;

  state_e                state_q, state_d;
  logic                  winner_q, winner_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  err_pend_q, err_pend_d;
  logic                  last_grant_q, last_grant_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  busy_q, busy_d;
  logic [NUM_PORTS-1:0]  io_wr_en_q, io_wr_en_d;
  logic [7:0]            io_wdata_q, io_wdata_d;

  logic                  gnt_id;
  logic [ADDR_W-1:0]     gnt_addr;
  logic [7:0]            gnt_data;
  logic                  gnt_oor;
  logic                  rb_err;

  // On a tie the requester that did not win last time is served.
  assign gnt_id   = (req0 & req1) ? ~last_grant_q : req1;
  assign gnt_addr = gnt_id ? addr1 : addr0;
  assign gnt_data = gnt_id ? data1 : data0;
  assign gnt_oor  = {{(32 - ADDR_W){1'b0}}, gnt_addr} >= NUM_PORTS;

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    addr_d       = addr_q;
    err_pend_d   = err_pend_q;
    last_grant_d = last_grant_q;
    io_wdata_d   = io_wdata_q;
    io_wr_en_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (req0 | req1) begin
          winner_d   = gnt_id;
          addr_d     = gnt_addr;
          io_wdata_d = gnt_data;
          err_pend_d = gnt_oor;
          if (gnt_oor) begin
            state_d = StDone;
          end else begin
            state_d = StIssue;
            for (int i = 0; i < NUM_PORTS; i++) begin
              io_wr_en_d[i] = (gnt_addr == ADDR_W'(i));
            end
          end
        end
      end
      StIssue: state_d = StHold;
      StHold:  state_d = StDone;
      StDone: begin
        last_grant_d = winner_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
    ack0_d = (state_d == StDone) && !winner_d;
    ack1_d = (state_d == StDone) && winner_d;
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      winner_q     <= 1'b0;
      addr_q       <= '0;
      err_pend_q   <= 1'b0;
      last_grant_q <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b0;
      io_wr_en_q   <= '0;
      io_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      addr_q       <= addr_d;
      err_pend_q   <= err_pend_d;
      last_grant_q <= last_grant_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      busy_q       <= busy_d;
      io_wr_en_q   <= io_wr_en_d;
      io_wdata_q   <= io_wdata_d;
    end
  end

`ifdef IO_READBACK_EN
  logic [7:0] rb_data;

  always_comb begin
    rb_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (addr_q == ADDR_W'(i)) rb_data = io_rdata[8*i +: 8];
    end
  end

  // The register committed at the end of HOLD, so its output is valid during DONE.
  assign rb_err = !err_pend_q && (rb_data != io_wdata_q);
`else
  logic unused_sig;
  assign unused_sig = ^{io_rdata, addr_q};
  assign rb_err     = 1'b0;
`endif

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign err      = (ack0_q | ack1_q) & (err_pend_q | rb_err);
  assign busy     = busy_q;
  assign io_wr_en = io_wr_en_q;
  assign io_wdata = io_wdata_q;

endmodule

// File: tb/tb_io_wr_arbiter.sv
// Self-checking bench for io_wr_arbiter: transaction-timeline model plus directed scenarios.
module tb_io_wr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] addr0 = '0, addr1 = '0;
  logic [7:0] data0 = '0, data1 = '0;
  logic       ack0, ack1, err, busy;
  logic [3:0] io_wr_en;
  logic [7:0] io_wdata;
  logic [31:0] io_rdata;

  logic       req0_3 = 1'b0, req1_3 = 1'b0;
  logic [1:0] addr0_3 = '0, addr1_3 = '0;
  logic [7:0] data0_3 = '0, data1_3 = '0;
  logic       ack0_3, ack1_3, err_3, busy_3;
  logic [2:0] io_wr_en_3;
  logic [7:0] io_wdata_3;
  logic [23:0] io_rdata_3;
  assign io_rdata_3 = '0;

  io_wr_arbiter #(.NUM_PORTS(4), .ADDR_W(2)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1),
    .err(err), .busy(busy), .io_wr_en(io_wr_en), .io_wdata(io_wdata), .io_rdata(io_rdata)
  );

  io_wr_arbiter #(.NUM_PORTS(3), .ADDR_W(2)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0(req0_3), .addr0(addr0_3), .data0(data0_3), .ack0(ack0_3),
    .req1(req1_3), .addr1(addr1_3), .data1(data1_3), .ack1(ack1_3),
    .err(err_3), .busy(busy_3), .io_wr_en(io_wr_en_3), .io_wdata(io_wdata_3),
    .io_rdata(io_rdata_3)
  );

  // IO register bank: enable captured on one edge, data committed on the next.
  logic [7:0] regs [4];
  logic [3:0] en_q = '0;
  bit         ovr1 = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) en_q <= '0;
    else begin
      en_q <= io_wr_en;
      for (int i = 0; i < 4; i++) if (en_q[i]) regs[i] <= io_wdata;
    end
  end

  always_comb begin
    io_rdata = '0;
    for (int i = 0; i < 4; i++) io_rdata[8*i +: 8] = (i == 1 && ovr1) ? 8'h00 : regs[i];
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a transaction granted at cycle g writes in g, acks in g+len, idles after.
  int         cyc = 0, m_g = 0, m_len = 0, m_prev = 0;
  bit         m_act = 1'b0, m_bad = 1'b0, m_id = 1'b0, m_last = 1'b1;
  logic [1:0] m_addr = '0;
  logic [7:0] m_wdata = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 1'b0; m_last = 1'b1; m_wdata = '0; cyc = 0;
    end else begin
      m_prev = cyc;
      cyc = cyc + 1;
      if (m_act && (m_prev - m_g == m_len)) m_last = m_id;
      if ((!m_act || (m_prev - m_g > m_len)) && (req0 || req1)) begin
        m_id    = (req0 && req1) ? !m_last : req1;
        m_addr  = m_id ? addr1 : addr0;
        m_wdata = m_id ? data1 : data0;
        m_bad   = ({1'b0, m_addr} >= 3'd4);
        m_act   = 1'b1;
        m_g     = cyc;
        m_len   = m_bad ? 0 : 2;
      end
    end
  end

  task automatic check_cycle();
    int d;
    logic [3:0] e_wr;
    bit e_a0, e_a1, e_busy, e_rb;
    d      = cyc - m_g;
    e_wr   = (m_act && d == 0 && !m_bad) ? (4'b0001 << m_addr) : 4'b0000;
    e_a0   = m_act && d == m_len && !m_id;
    e_a1   = m_act && d == m_len && m_id;
    e_busy = m_act && d >= 0 && d <= m_len;
`ifdef IO_READBACK_EN
    e_rb = !m_bad && (io_rdata[8*m_addr +: 8] != m_wdata);
`else
    e_rb = 1'b0;
`endif
    chk("io_wr_en", io_wr_en, e_wr);
    chk("io_wdata", io_wdata, m_wdata);
    chk("ack0", ack0, e_a0);
    chk("ack1", ack1, e_a1);
    chk("busy", busy, e_busy);
    if (e_a0 || e_a1) chk("err", err, m_bad || e_rb);
    chk("io_wr_en_3", io_wr_en_3, 3'b000);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      check_cycle();
    end
  end

  logic [3:0] wr1, wr2;
  int ord [8];
  int tim [8];
  int idle_cnt;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic xfer(input bit id, input logic [1:0] a, input logic [7:0] dv,
                      input int exp_lat, input bit exp_err, input bit chk_rd, input string nm);
    int cnt;
    bit got;
    cnt = 0;
    got = 1'b0;
    @(negedge clk);
    if (id) begin req1 = 1'b1; addr1 = a; data1 = dv; end
    else    begin req0 = 1'b1; addr0 = a; data0 = dv; end
    while (!got && cnt < 12) begin
      @(posedge clk);
      #2;
      cnt++;
      if (cnt == 1) wr1 = io_wr_en;
      if (cnt == 2) wr2 = io_wr_en;
      if ((id ? ack1 : ack0) === 1'b1) got = 1'b1;
    end
    chk({nm, "_acked"}, got, 1);
    if (got) begin
      chk({nm, "_latency"}, cnt, exp_lat);
      chk({nm, "_err"}, err, exp_err);
      if (chk_rd) chk({nm, "_rdata"}, io_rdata[8*a +: 8], dv);
    end
    @(negedge clk);
    if (id) req1 = 1'b0;
    else    req0 = 1'b0;
  endtask

  task automatic run_both(input int n);
    int k, t;
    k = 0;
    t = 0;
    idle_cnt = 0;
    @(negedge clk);
    req0 = 1'b1;
    req1 = 1'b1;
    while (k < n && t < 60) begin
      @(posedge clk);
      #2;
      t++;
      if (k > 0 && busy === 1'b0) idle_cnt++;
      if (ack0 === 1'b1) begin ord[k] = 0; tim[k] = t; k++; end
      else if (ack1 === 1'b1) begin ord[k] = 1; tim[k] = t; k++; end
    end
    chk("both_ack_count", k, n);
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    bit got;
    logic [7:0] r0;
    for (int i = 0; i < 4; i++) regs[i] = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_wr_en", io_wr_en, 0);
    chk("reset_wdata", io_wdata, 0);
    chk("reset_acks", {ack0, ack1, err}, 0);

    // Single write to port 2
    xfer(1'b0, 2'd2, 8'hA5, 3, 1'b0, 1'b1, "t1");
    chk("t1_wr_en_issue", wr1, 4'b0100);
    chk("t1_wr_en_hold", wr2, 4'b0000);

    // Simultaneous requests: requester 0 wins the first tie
    do_reset();
    data0 = 8'h11; addr0 = 2'd0; data1 = 8'h22; addr1 = 2'd1;
    run_both(2);
    chk("t2_first", ord[0], 0);
    chk("t2_second", ord[1], 1);
    chk("t2_first_lat", tim[0], 3);
    chk("t2_spacing", tim[1] - tim[0], 4);
    chk("t2_port0", io_rdata[7:0], 8'h11);
    chk("t2_port1", io_rdata[15:8], 8'h22);

    // Fairness over six back-to-back transactions
    do_reset();
    addr0 = 2'd3; data0 = 8'h3A; addr1 = 2'd2; data1 = 8'h4B;
    run_both(6);
    for (int i = 0; i < 6; i++) chk("t3_order", ord[i], i % 2);
    for (int i = 1; i < 6; i++) chk("t3_spacing", tim[i] - tim[i-1], 4);
    chk("t3_idle_cycles", idle_cnt, 5);

    // Out-of-range address on a 3-port instance
    cnt = 0;
    got = 1'b0;
    @(negedge clk);
    req1_3 = 1'b1; addr1_3 = 2'd3; data1_3 = 8'h77;
    while (!got && cnt < 6) begin
      @(posedge clk);
      #2;
      cnt++;
      if (ack1_3 === 1'b1) got = 1'b1;
    end
    chk("t4_acked", got, 1);
    chk("t4_latency", cnt, 1);
    chk("t4_err", err_3, 1);
    chk("t4_ack0", ack0_3, 0);
    chk("t4_busy", busy_3, 1);
    @(negedge clk);
    req1_3 = 1'b0;
    @(posedge clk);
    #2;
    chk("t4_idle_busy", busy_3, 0);
    chk("t4_idle_ack", ack1_3, 0);

    // Reset during HOLD
    do_reset();
    @(negedge clk);
    req0 = 1'b1; addr0 = 2'd3; data0 = 8'h5A;
    regs[3] = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    req0 = 1'b0;
    #1;
    chk("t5_ack0", ack0, 0);
    chk("t5_busy", busy, 0);
    chk("t5_wr_en", io_wr_en, 0);
    chk("t5_wdata", io_wdata, 0);
    chk("t5_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("t5_port3_unchanged", io_rdata[31:24], 8'h00);
    xfer(1'b0, 2'd3, 8'h5A, 3, 1'b0, 1'b1, "t5_after");

    // Readback mismatch forced on port 1
    ovr1 = 1'b1;
`ifdef IO_READBACK_EN
    xfer(1'b1, 2'd1, 8'h3C, 3, 1'b1, 1'b0, "t6");
`else
    xfer(1'b1, 2'd1, 8'h3C, 3, 1'b0, 1'b0, "t6");
`endif
    ovr1 = 1'b0;
    #1;
    chk("t6_port1_committed", io_rdata[15:8], 8'h3C);

    // Request dropped and operands changed after grant
    r0 = io_rdata[7:0];
    cnt = 0;
    got = 1'b0;
    @(negedge clk);
    req1 = 1'b1; addr1 = 2'd2; data1 = 8'hC3;
    @(posedge clk);
    #2;
    cnt++;
    @(negedge clk);
    req1 = 1'b0; addr1 = 2'd0; data1 = 8'hFF;
    while (!got && cnt < 8) begin
      @(posedge clk);
      #2;
      cnt++;
      if (ack1 === 1'b1) got = 1'b1;
    end
    chk("t7_acked", got, 1);
    chk("t7_latency", cnt, 3);
    chk("t7_port2", io_rdata[23:16], 8'hC3);
    chk("t7_port0_unchanged", io_rdata[7:0], r0);
    repeat (3) @(posedge clk);
    #3;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
